dma_burst_ctrl: RTL and testbench

- Multi-channel burst DMA engine between the PI bus side and the mapper memories (PRG, CHR, SRM, plus extra channels).
- Accepts one descriptor (channel, start address, length, direction), then runs a byte-serial transfer.
- Address auto-increments; memory strobes are stretched to a programmable wait count.
- Replaces per-access combinational routing with a sequenced, arbitrated engine carrying busy/done status.

---
 rtl/dma_pkg.sv | 26 ++
 rtl/dma_rd_mux.sv | 22 ++
 rtl/dma_burst_ctrl.sv | 155 +++++++++++++++
 tb/tb_dma_burst_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the burst DMA engine and its helpers.
package dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAITW  = 3'd1,
        ST_STROBE = 3'd2,
        ST_NEXT   = 3'd3,
        ST_FIN    = 3'd4
    } dma_st_t;

    localparam int unsigned CH_PRG = 0;
    localparam int unsigned CH_CHR = 1;
    localparam int unsigned CH_SRM = 2;

    localparam logic [7:0] DMA_RD_DEF = 8'hFF;

    // Widest supported descriptor; users slice down to their AW/LW/channel width.
    typedef struct packed {
        logic        we;
        logic [7:0]  ch;
        logic [31:0] addr;
        logic [31:0] len;
    } dma_desc_t;

endpackage

// File: rtl/dma_rd_mux.sv
// Per-channel read-data selector; an out-of-range channel reads as DMA_RD_DEF.
module dma_rd_mux
    import dma_pkg::*;
#(
    parameter int unsigned NCH = 3,
    parameter int unsigned CW  = 2
) (
    input  logic [CW-1:0]      ch,
    input  logic [NCH*8-1:0]   mem_do,
    output logic [7:0]         dout
);

    always_comb begin
        dout = DMA_RD_DEF;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (ch == CW'(k)) begin
                dout = mem_do[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/dma_burst_ctrl.sv
// Byte-serial burst DMA between the PI side and the mapper memories.
// Optional abort input enabled by defining DMA_ABORT_EN.
module dma_burst_ctrl
    import dma_pkg::*;
#(
    parameter int unsigned NCH      = 3,
    parameter int unsigned AW       = 23,
    parameter int unsigned LW       = 16,
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic                     req_we,
    input  logic [$clog2(NCH)-1:0]   req_ch,
    input  logic [AW-1:0]            req_addr,
    input  logic [LW-1:0]            req_len,
    input  logic [7:0]               wr_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    output logic [7:0]               rd_data,
    output logic                     rd_valid,
    output logic                     busy,
    output logic                     done,
    output logic [AW-1:0]            mem_addr,
    output logic [7:0]               mem_dati,
    output logic [NCH-1:0]           mem_ce,
    output logic                     mem_oe,
    output logic                     mem_we,
    input  logic [NCH*8-1:0]         mem_do
`ifdef DMA_ABORT_EN
    ,
    input  logic                     abort
`endif
);

    localparam int unsigned CW    = $clog2(NCH);
    localparam logic [3:0]  WLOAD = 4'(MEM_WAIT - 1);

    dma_st_t        st;
    logic           we_r;
    logic [CW-1:0]  ch_r;
    logic [AW-1:0]  addr_r;
    logic [LW-1:0]  cnt_r;
    logic [3:0]     wcnt;
    logic [7:0]     dati_r;
    logic [7:0]     rdat_r;
    logic           samp_d;
    logic           rv_r;
    logic           abort_pend;
    logic           abort_in;
    logic [7:0]     mux_out;

`ifdef DMA_ABORT_EN
    assign abort_in = abort;
`else
    assign abort_in = 1'b0;
`endif

    dma_rd_mux #(
        .NCH (NCH),
        .CW  (CW)
    ) u_rd_mux (
        .ch     (ch_r),
        .mem_do (mem_do),
        .dout   (mux_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= ST_IDLE;
            we_r       <= 1'b0;
            ch_r       <= '0;
            addr_r     <= '0;
            cnt_r      <= '0;
            wcnt       <= '0;
            dati_r     <= '0;
            rdat_r     <= DMA_RD_DEF;
            samp_d     <= 1'b0;
            rv_r       <= 1'b0;
            abort_pend <= 1'b0;
        end else begin
            // rd_valid trails the sampling edge by one extra cycle
            samp_d <= 1'b0;
            rv_r   <= samp_d;
            case (st)
                ST_IDLE: begin
                    abort_pend <= 1'b0;
                    if (req_valid) begin
                        we_r   <= req_we;
                        ch_r   <= req_ch;
                        addr_r <= req_addr;
                        cnt_r  <= req_len;
                        wcnt   <= WLOAD;
                        st     <= req_we ? ST_WAITW : ST_STROBE;
                    end
                end
                ST_WAITW: begin
                    if (abort_in) begin
                        st <= ST_FIN;
                    end else if (wr_valid) begin
                        dati_r <= wr_data;
                        wcnt   <= WLOAD;
                        st     <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    if (abort_in) begin
                        abort_pend <= 1'b1;
                    end
                    if (wcnt == 4'd0) begin
                        if (!we_r) begin
                            rdat_r <= mux_out;
                            samp_d <= 1'b1;
                        end
                        st <= ST_NEXT;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                ST_NEXT: begin
                    if (cnt_r == '0 || abort_pend || abort_in) begin
                        st <= ST_FIN;
                    end else begin
                        cnt_r  <= cnt_r - 1'b1;
                        addr_r <= addr_r + 1'b1;
                        wcnt   <= WLOAD;
                        st     <= we_r ? ST_WAITW : ST_STROBE;
                    end
                end
                ST_FIN:  st <= ST_IDLE;
                default: st <= ST_IDLE;
            endcase
        end
    end

    // Chip enable decodes only legal channels, so an invalid one leaves mem_ce clear.
    always_comb begin
        mem_ce = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            mem_ce[k] = (st == ST_STROBE) && (ch_r == CW'(k));
        end
    end

    assign mem_oe   = (st == ST_STROBE) && !we_r;
    assign mem_we   = (st == ST_STROBE) && we_r;
    assign wr_ready = (st == ST_WAITW) && wr_valid && !abort_in;
    assign busy     = (st != ST_IDLE);
    assign done     = (st == ST_FIN);
    assign mem_addr = addr_r;
    assign mem_dati = dati_r;
    assign rd_data  = rdat_r;
    assign rd_valid = rv_r;

endmodule

// File: tb/tb_dma_burst_ctrl.sv
// Self-checking bench for dma_burst_ctrl: directed plan steps plus random transfers.
`timescale 1ns/1ps
module tb_dma_burst_ctrl;
    import dma_pkg::*;

    localparam int NCH = 3;
    localparam int AW  = 23;
    localparam int LW  = 16;
    localparam int MW  = 2;
    localparam int CW  = $clog2(NCH);

    typedef logic [7:0] byte_q_t[$];
    typedef int         int_q_t[$];

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               req_valid = 1'b0;
    logic               req_we = 1'b0;
    logic [CW-1:0]      req_ch = '0;
    logic [AW-1:0]      req_addr = '0;
    logic [LW-1:0]      req_len = '0;
    logic [7:0]         wr_data = '0;
    logic               wr_valid = 1'b0;
    logic               wr_ready;
    logic [7:0]         rd_data;
    logic               rd_valid;
    logic               busy;
    logic               done;
    logic [AW-1:0]      mem_addr;
    logic [7:0]         mem_dati;
    logic [NCH-1:0]     mem_ce;
    logic               mem_oe;
    logic               mem_we;
    logic [NCH*8-1:0]   mem_do;
`ifdef DMA_ABORT_EN
    logic               abort = 1'b0;
`endif

    always #5 clk = ~clk;

    dma_burst_ctrl #(
        .NCH      (NCH),
        .AW       (AW),
        .LW       (LW),
        .MEM_WAIT (MW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_ch    (req_ch),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_dati  (mem_dati),
        .mem_ce    (mem_ce),
        .mem_oe    (mem_oe),
        .mem_we    (mem_we),
        .mem_do    (mem_do)
`ifdef DMA_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    // Memory model: channel k returns low address byte plus k*0x40.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            mem_do[8*k +: 8] = mem_addr[7:0] + 8'(k * 64);
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int               rv_t[$];
    logic [7:0]       rv_d[$];
    int               done_t[$];
    logic [AW-1:0]    st_addr[$];
    logic [NCH-1:0]   st_ce[$];
    logic [7:0]       st_dat[$];
    logic             st_we[$];
    int               st_len[$];
    int               wrr_cnt = 0;
    int               busy_cnt = 0;
    int               inv_err = 0;
    logic             prev_stb = 1'b0;

    always @(negedge clk) begin
        if (rd_valid) begin
            rv_t.push_back(cyc);
            rv_d.push_back(rd_data);
        end
        if (done) done_t.push_back(cyc);
        if (wr_ready) wrr_cnt++;
        if (busy) busy_cnt++;
        if (mem_oe && mem_we) inv_err++;
        if (mem_ce != '0 && !(mem_oe || mem_we)) inv_err++;
        if (!$onehot0(mem_ce)) inv_err++;
        if (mem_oe || mem_we) begin
            if (!prev_stb) begin
                st_addr.push_back(mem_addr);
                st_ce.push_back(mem_ce);
                st_dat.push_back(mem_dati);
                st_we.push_back(mem_we);
                st_len.push_back(1);
            end else begin
                st_len[st_len.size()-1] += 1;
                if (mem_addr !== st_addr[st_addr.size()-1] || mem_ce !== st_ce[st_ce.size()-1])
                    inv_err++;
            end
        end
        prev_stb = mem_oe || mem_we;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] exp_addr(input dma_desc_t d, input int k);
        return AW'(d.addr + 32'(k));
    endfunction

    function automatic logic [NCH-1:0] exp_ce(input logic [7:0] ch);
        logic [NCH-1:0] r = '0;
        if (int'(ch) < NCH) r[ch] = 1'b1;
        return r;
    endfunction

    function automatic logic [7:0] exp_rd(input logic [7:0] ch, input logic [AW-1:0] a);
        if (int'(ch) < NCH) return a[7:0] + 8'(int'(ch) * 64);
        return 8'hFF;
    endfunction

    task automatic clear_mon();
        rv_t.delete(); rv_d.delete(); done_t.delete();
        st_addr.delete(); st_ce.delete(); st_dat.delete(); st_we.delete(); st_len.delete();
        wrr_cnt = 0;
        busy_cnt = 0;
    endtask

    // Called at posedge+1; returns the cycle in which req_valid was presented.
    task automatic issue(input dma_desc_t d, output int t0);
        clear_mon();
        req_valid = 1'b1;
        req_we    = d.we;
        req_ch    = d.ch[CW-1:0];
        req_addr  = d.addr[AW-1:0];
        req_len   = d.len[LW-1:0];
        t0 = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_t.size() == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", done_t.size() > 0, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic check_common(input dma_desc_t d, input int n);
        chk("done_count", done_t.size(), 1);
        chk("busy_after", busy, 1'b0);
        chk("stb_count", st_addr.size(), n);
        for (int k = 0; k < n; k++) begin
            if (k < st_addr.size()) begin
                chk($sformatf("stb_addr[%0d]", k), st_addr[k], exp_addr(d, k));
                chk($sformatf("stb_ce[%0d]", k), st_ce[k], exp_ce(d.ch));
                chk($sformatf("stb_len[%0d]", k), st_len[k], MW);
                chk($sformatf("stb_dir[%0d]", k), st_we[k], d.we);
            end
        end
    endtask

    task automatic run_read(input dma_desc_t d, input logic spam);
        int t0;
        int n = int'(d.len) + 1;
        issue(d, t0);
        if (spam) begin
            @(posedge clk); #1;
            req_valid = 1'b1;
            req_we    = ~d.we;
            req_ch    = CW'(2);
            req_addr  = ~d.addr[AW-1:0];
            req_len   = LW'(9);
            @(posedge clk); #1;
            req_valid = 1'b0;
        end
        wait_done();
        check_common(d, n);
        chk("rd_count", rv_t.size(), n);
        for (int k = 0; k < n; k++) begin
            if (k < rv_t.size()) begin
                chk($sformatf("rd_time[%0d]", k), rv_t[k] - t0, MW + 2 + k * (MW + 1));
                chk($sformatf("rd_data[%0d]", k), rv_d[k], exp_rd(d.ch, exp_addr(d, k)));
            end
        end
        if (done_t.size() > 0) begin
            chk("done_time", done_t[0] - t0, n * (MW + 1) + 1);
            chk("busy_span", busy_cnt, done_t[0] - t0);
        end
    endtask

    task automatic run_write(input dma_desc_t d, input byte_q_t wd, input int_q_t dl);
        int t0;
        int n = int'(d.len) + 1;
        logic got;
        issue(d, t0);
        for (int b = 0; b < n; b++) begin
            repeat (dl[b]) begin @(posedge clk); #1; end
            wr_data  = wd[b];
            wr_valid = 1'b1;
            got = 1'b0;
            for (int w = 0; w < 200 && !got; w++) begin
                @(negedge clk);
                if (wr_ready) got = 1'b1;
                @(posedge clk); #1;
            end
            wr_valid = 1'b0;
            if (!got) chk("wr_ready_timeout", got, 1'b1);
        end
        wait_done();
        check_common(d, n);
        chk("wr_ready_count", wrr_cnt, n);
        chk("rd_during_write", rv_t.size(), 0);
        for (int k = 0; k < n; k++) begin
            if (k < st_dat.size())
                chk($sformatf("wr_data[%0d]", k), st_dat[k], wd[k]);
        end
        if (done_t.size() > 0) chk("busy_span", busy_cnt, done_t[0] - t0);
    endtask

    initial begin
        dma_desc_t d;
        byte_q_t   wd;
        int_q_t    dl;
        int        t0;
        int        nd;

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rd_data", rd_data, 8'hFF);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_strobes", {mem_ce, mem_oe, mem_we, wr_ready}, '0);
        chk("rst_addr", mem_addr, '0);
        chk("rst_dati", mem_dati, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        d = '{we: 1'b0, ch: 8'd0, addr: 32'h100, len: 32'd3};
        run_read(d, 1'b0);

        d = '{we: 1'b1, ch: 8'd2, addr: 32'h7FFFFF, len: 32'd1};
        wd = '{8'hA5, 8'h5A};
        dl = '{0, 5};
        run_write(d, wd, dl);

        d = '{we: 1'b0, ch: 8'd3, addr: 32'h1234, len: 32'd0};
        run_read(d, 1'b0);

        d = '{we: 1'b0, ch: 8'd1, addr: 32'h2F0, len: 32'd4};
        run_read(d, 1'b1);

        for (int i = 0; i < 8; i++) begin
            d.we   = $urandom_range(0, 1);
            d.ch   = 8'($urandom_range(0, 3));
            d.addr = 32'($urandom) & 32'h7FFFFF;
            if ($urandom_range(0, 2) == 0) d.addr = 32'h7FFFFF - 32'($urandom_range(0, 2));
            d.len  = 32'($urandom_range(0, 5));
            if (d.we) begin
                wd.delete();
                dl.delete();
                for (int b = 0; b <= int'(d.len); b++) begin
                    wd.push_back(8'($urandom));
                    dl.push_back($urandom_range(0, 3));
                end
                run_write(d, wd, dl);
            end else begin
                run_read(d, 1'b0);
            end
        end

`ifdef DMA_ABORT_EN
        d = '{we: 1'b0, ch: 8'd1, addr: 32'h40, len: 32'd7};
        issue(d, t0);
        repeat (3) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_done();
        chk("abort_rd_count", rv_t.size(), 2);
        chk("abort_done_count", done_t.size(), 1);
        if (done_t.size() > 0) chk("abort_done_time", done_t[0] - t0, 7);
        if (rv_d.size() > 1) chk("abort_rd_data", rv_d[1], exp_rd(d.ch, exp_addr(d, 1)));
`endif

        d = '{we: 1'b0, ch: 8'd0, addr: 32'h500, len: 32'd9};
        issue(d, t0);
        repeat (3) begin @(posedge clk); #1; end
        chk("pre_rst_strobe", mem_oe, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_strobes", {mem_ce, mem_oe, mem_we}, '0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_rd_data", rd_data, 8'hFF);
        chk("mid_rst_rd_valid", rd_valid, 1'b0);
        nd = done_t.size();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (40) begin @(posedge clk); #1; end
        chk("mid_rst_no_done", done_t.size(), nd);
        chk("mid_rst_idle", busy, 1'b0);

        chk("invariants", inv_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
